spi_frame_receiver: RTL and testbench

// SPI slave receive stage directly downstream of the SPI synchronizer. Consumes the single-cycle
// ss_bar edge pulses and the sck falling-edge pulse, already in the 50 MHz clk domain, plus the raw

---
 rtl/spi_frame_receiver_if.sv | 30 +++
 rtl/spi_frame_receiver.sv | 159 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_receiver_if.sv
// Bus between the SPI synchronizer side and the frame receiver.
// The master side drives the strobes and MOSI; the slave side is the receiver.
interface spi_frame_receiver_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FRAME_WORDS = 4
);
    localparam int unsigned IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    logic                          ssbar_synced_ne;
    logic                          ssbar_synced_pe;
    logic                          sck_synced;
    logic                          mosi;
    logic [DATA_W-1:0]             word_data;
    logic                          word_valid;
    logic [IDX_W-1:0]              word_index;
    logic [DATA_W*FRAME_WORDS-1:0] frame_data;
    logic                          frame_valid;
    logic                          frame_error;
    logic                          busy;

    modport master (
        output ssbar_synced_ne, ssbar_synced_pe, sck_synced, mosi,
        input  word_data, word_valid, word_index, frame_data, frame_valid, frame_error, busy
    );

    modport slave (
        input  ssbar_synced_ne, ssbar_synced_pe, sck_synced, mosi,
        output word_data, word_valid, word_index, frame_data, frame_valid, frame_error, busy
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI slave receive stage: assembles MOSI bits into words and a fixed-length frame,
// then issues a one-cycle frame_valid or frame_error verdict when ss_bar rises.
module spi_frame_receiver #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FRAME_WORDS = 4,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_frame_receiver_if.slave  bus
);
    localparam int unsigned BC_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WC_W    = $clog2(FRAME_WORDS + 1);
    localparam int unsigned IDX_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned FRAME_W = DATA_W * FRAME_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 mosi_meta_q, mosi_s_q;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic                 overflow_q, overflow_d;
    logic [FRAME_W-1:0]   staging_q, staging_d;
    logic [DATA_W-1:0]    word_data_q, word_data_d;
    logic                 word_valid_q, word_valid_d;
    logic [IDX_W-1:0]     word_index_q, word_index_d;
    logic [FRAME_W-1:0]   frame_data_q, frame_data_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 busy_q, busy_d;
    logic [DATA_W-1:0]    shift_nxt_c;

    assign shift_nxt_c = MSB_FIRST ? {shift_q[DATA_W-2:0], mosi_s_q}
                                   : {mosi_s_q, shift_q[DATA_W-1:1]};

    // Next-state, datapath and output strobes
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        shift_d       = shift_q;
        overflow_d    = overflow_q;
        staging_d     = staging_q;
        word_data_d   = word_data_q;
        word_index_d  = word_index_q;
        frame_data_d  = frame_data_q;
        word_valid_d  = 1'b0;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ssbar_synced_ne) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bus.ssbar_synced_ne) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (bus.sck_synced) begin
                        shift_d = shift_nxt_c;
                        if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            if (word_cnt_q < WC_W'(FRAME_WORDS)) begin
                                word_valid_d = 1'b1;
                                word_data_d  = shift_nxt_c;
                                word_index_d = IDX_W'(word_cnt_q);
                                word_cnt_d   = word_cnt_q + WC_W'(1);
                                for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
                                    if (word_cnt_q == WC_W'(i)) begin
                                        staging_d[(FRAME_WORDS-1-i)*DATA_W +: DATA_W] = shift_nxt_c;
                                    end
                                end
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                    // The bit arriving with the rising ss_bar is kept before checking
                    if (bus.ssbar_synced_pe) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if ((word_cnt_q == WC_W'(FRAME_WORDS)) && (bit_cnt_q == '0) && !overflow_q) begin
                    frame_valid_d = 1'b1;
                    frame_data_d  = staging_q;
                end else begin
                    frame_error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mosi_meta_q   <= 1'b0;
            mosi_s_q      <= 1'b0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            shift_q       <= '0;
            overflow_q    <= 1'b0;
            staging_q     <= '0;
            word_data_q   <= '0;
            word_valid_q  <= 1'b0;
            word_index_q  <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mosi_meta_q   <= bus.mosi;
            mosi_s_q      <= mosi_meta_q;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shift_q       <= shift_d;
            overflow_q    <= overflow_d;
            staging_q     <= staging_d;
            word_data_q   <= word_data_d;
            word_valid_q  <= word_valid_d;
            word_index_q  <= word_index_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.word_data   = word_data_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.word_index  = word_index_q;
    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: one MSB-first and one LSB-first instance
// share the same stimulus; expected values are hand-computed constants.
module tb_spi_frame_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ne = 1'b0, pe = 1'b0, sck = 1'b0, mosi = 1'b0;

    always #10 clk = ~clk;

    spi_frame_receiver_if #(.DATA_W(8), .FRAME_WORDS(4)) ifm ();
    spi_frame_receiver_if #(.DATA_W(8), .FRAME_WORDS(4)) ifl ();

    assign ifm.ssbar_synced_ne = ne;
    assign ifm.ssbar_synced_pe = pe;
    assign ifm.sck_synced      = sck;
    assign ifm.mosi            = mosi;
    assign ifl.ssbar_synced_ne = ne;
    assign ifl.ssbar_synced_pe = pe;
    assign ifl.sck_synced      = sck;
    assign ifl.mosi            = mosi;

    spi_frame_receiver #(.DATA_W(8), .FRAME_WORDS(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bus(ifm.slave));
    spi_frame_receiver #(.DATA_W(8), .FRAME_WORDS(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bus(ifl.slave));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pe_cyc = 0, sck_cyc = 0;
    int wv_total = 0, fv_total = 0, fe_total = 0, both_total = 0;
    int wv_cyc = 0, fv_cyc = 0, fe_cyc = 0;
    int l_wv_total = 0, l_fv_total = 0;
    logic [7:0] wd_log[$];
    logic [1:0] wi_log[$];
    int b_wv, b_fv, b_fe;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ifm.word_valid) begin
            wv_total++;
            wv_cyc = cyc;
            wd_log.push_back(ifm.word_data);
            wi_log.push_back(ifm.word_index);
        end
        if (ifm.frame_valid) begin fv_total++; fv_cyc = cyc; end
        if (ifm.frame_error) begin fe_total++; fe_cyc = cyc; end
        if (ifm.frame_valid && ifm.frame_error) both_total++;
        if (ifl.word_valid) l_wv_total++;
        if (ifl.frame_valid) l_fv_total++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_wv = wv_total;
        b_fv = fv_total;
        b_fe = fe_total;
    endtask

    task automatic start_frame();
        ne = 1'b1;
        step();
        ne = 1'b0;
        repeat (2) step();
    endtask

    task automatic end_frame();
        pe = 1'b1;
        pe_cyc = cyc;
        step();
        pe = 1'b0;
        repeat (5) step();
    endtask

    task automatic send_bit(input logic b, input int half, input logic with_pe);
        mosi = b;
        repeat (half - 1) step();
        sck = 1'b1;
        sck_cyc = cyc;
        if (with_pe) begin
            pe = 1'b1;
            pe_cyc = cyc;
        end
        step();
        sck = 1'b0;
        pe = 1'b0;
        repeat (half - 1) step();
    endtask

    task automatic send_word(input logic [7:0] w, input int half, input logic pe_last,
                             input logic msb);
        logic [7:0] v;
        v = w;
        for (int i = 0; i < 8; i++) begin
            send_bit(msb ? v[7-i] : v[i], half, pe_last && (i == 7));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_word_data",   64'(ifm.word_data),   64'h0);
        check("rst_word_valid",  64'(ifm.word_valid),  64'h0);
        check("rst_word_index",  64'(ifm.word_index),  64'h0);
        check("rst_frame_data",  64'(ifm.frame_data),  64'h0);
        check("rst_frame_valid", 64'(ifm.frame_valid), 64'h0);
        check("rst_frame_error", 64'(ifm.frame_error), 64'h0);
        check("rst_busy",        64'(ifm.busy),        64'h0);
        rst = 1'b0;
        repeat (2) step();

        // Good frame at 1 MHz SCK
        snap();
        start_frame();
        check("t1_busy", 64'(ifm.busy), 64'h1);
        send_word(8'h12, 25, 1'b0, 1'b1);
        send_word(8'h34, 25, 1'b0, 1'b1);
        send_word(8'h56, 25, 1'b0, 1'b1);
        send_word(8'h78, 25, 1'b0, 1'b1);
        check("t1_wv_lat", 64'(wv_cyc - sck_cyc), 64'd1);
        end_frame();
        check("t1_wv_cnt", 64'(wv_total - b_wv), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_wi", 64'(wi_log[b_wv+i]), 64'(i));
        end
        check("t1_wd0", 64'(wd_log[b_wv]),   64'h12);
        check("t1_wd3", 64'(wd_log[b_wv+3]), 64'h78);
        check("t1_fv_cnt", 64'(fv_total - b_fv), 64'd1);
        check("t1_fe_cnt", 64'(fe_total - b_fe), 64'd0);
        check("t1_fv_lat", 64'(fv_cyc - pe_cyc), 64'd2);
        check("t1_frame",  64'(ifm.frame_data), 64'h12345678);
        check("t1_busy_end", 64'(ifm.busy), 64'h0);

        // Short frame
        snap();
        start_frame();
        send_word(8'hA5, 4, 1'b0, 1'b1);
        send_word(8'h5A, 4, 1'b0, 1'b1);
        end_frame();
        check("t2_wv_cnt", 64'(wv_total - b_wv), 64'd2);
        check("t2_wd0", 64'(wd_log[b_wv]),   64'hA5);
        check("t2_wd1", 64'(wd_log[b_wv+1]), 64'h5A);
        check("t2_fe_cnt", 64'(fe_total - b_fe), 64'd1);
        check("t2_fv_cnt", 64'(fv_total - b_fv), 64'd0);
        check("t2_fe_lat", 64'(fe_cyc - pe_cyc), 64'd2);
        check("t2_frame",  64'(ifm.frame_data), 64'h12345678);

        // Four words plus three stray bits
        snap();
        start_frame();
        send_word(8'h11, 4, 1'b0, 1'b1);
        send_word(8'h22, 4, 1'b0, 1'b1);
        send_word(8'h33, 4, 1'b0, 1'b1);
        send_word(8'h44, 4, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 4, 1'b0);
        end_frame();
        check("t3a_wv_cnt", 64'(wv_total - b_wv), 64'd4);
        check("t3a_fe_cnt", 64'(fe_total - b_fe), 64'd1);
        check("t3a_fv_cnt", 64'(fv_total - b_fv), 64'd0);

        // Five whole words: overflow
        snap();
        start_frame();
        for (int i = 1; i <= 5; i++) send_word(8'(i), 4, 1'b0, 1'b1);
        end_frame();
        check("t3b_wv_cnt", 64'(wv_total - b_wv), 64'd4);
        check("t3b_wd_last", 64'(wd_log[wd_log.size()-1]), 64'h04);
        check("t3b_fe_cnt", 64'(fe_total - b_fe), 64'd1);
        check("t3b_fv_cnt", 64'(fv_total - b_fv), 64'd0);
        check("t3b_frame",  64'(ifm.frame_data), 64'h12345678);

        // Reset in the middle of a frame
        snap();
        start_frame();
        send_word(8'hAB, 4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 4, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_word_data",  64'(ifm.word_data),  64'h0);
        check("t4_word_index", 64'(ifm.word_index), 64'h0);
        check("t4_frame_data", 64'(ifm.frame_data), 64'h0);
        check("t4_busy",       64'(ifm.busy),       64'h0);
        repeat (5) step();
        check("t4_no_strobe", 64'((fv_total - b_fv) + (fe_total - b_fe)), 64'd0);
        snap();
        start_frame();
        send_word(8'hDE, 4, 1'b0, 1'b1);
        send_word(8'hAD, 4, 1'b0, 1'b1);
        send_word(8'hBE, 4, 1'b0, 1'b1);
        send_word(8'hEF, 4, 1'b0, 1'b1);
        end_frame();
        check("t4_fv_cnt", 64'(fv_total - b_fv), 64'd1);
        check("t4_frame",  64'(ifm.frame_data), 64'hDEADBEEF);

        // Last bit coincident with ss_bar rising
        snap();
        start_frame();
        send_word(8'h10, 4, 1'b0, 1'b1);
        send_word(8'h20, 4, 1'b0, 1'b1);
        send_word(8'h30, 4, 1'b0, 1'b1);
        send_word(8'h40, 4, 1'b1, 1'b1);
        repeat (5) step();
        check("t5_wv_cnt", 64'(wv_total - b_wv), 64'd4);
        check("t5_wi_last", 64'(wi_log[wi_log.size()-1]), 64'd3);
        check("t5_wd_last", 64'(wd_log[wd_log.size()-1]), 64'h40);
        check("t5_fv_cnt", 64'(fv_total - b_fv), 64'd1);
        check("t5_fv_lat", 64'(fv_cyc - pe_cyc), 64'd2);
        check("t5_frame",  64'(ifm.frame_data), 64'h10203040);

        // LSB-first instance
        begin
            int lwv, lfv;
            lwv = l_wv_total;
            lfv = l_fv_total;
            start_frame();
            send_word(8'h48, 4, 1'b0, 1'b0);
            repeat (2) step();
            check("t5l_word_data", 64'(ifl.word_data), 64'h48);
            send_word(8'h11, 4, 1'b0, 1'b0);
            send_word(8'h22, 4, 1'b0, 1'b0);
            send_word(8'h33, 4, 1'b1, 1'b0);
            repeat (5) step();
            check("t5l_wv_cnt", 64'(l_wv_total - lwv), 64'd4);
            check("t5l_fv_cnt", 64'(l_fv_total - lfv), 64'd1);
            check("t5l_frame",  64'(ifl.frame_data), 64'h48112233);
        end

        // Restart after 10 bits, then a good frame
        snap();
        start_frame();
        send_word(8'h99, 4, 1'b0, 1'b1);
        send_bit(1'b1, 4, 1'b0);
        send_bit(1'b0, 4, 1'b0);
        start_frame();
        send_word(8'hCA, 4, 1'b0, 1'b1);
        send_word(8'hFE, 4, 1'b0, 1'b1);
        send_word(8'hF0, 4, 1'b0, 1'b1);
        send_word(8'h0D, 4, 1'b0, 1'b1);
        end_frame();
        check("t6_wv_cnt", 64'(wv_total - b_wv), 64'd5);
        check("t6_wd_first", 64'(wd_log[b_wv+1]), 64'hCA);
        check("t6_wi_last", 64'(wi_log[wi_log.size()-1]), 64'd3);
        check("t6_fe_cnt", 64'(fe_total - b_fe), 64'd0);
        check("t6_fv_cnt", 64'(fv_total - b_fv), 64'd1);
        check("t6_frame",  64'(ifm.frame_data), 64'hCAFEF00D);

        check("never_both", 64'(both_total), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
